// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory access controller: FSM state encoding and
// default timing parameters.
package mem_access_pkg;

    localparam int unsigned WAIT_MAX_DEFAULT = 8;
    localparam int unsigned CNT_W_DEFAULT    = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ADDR    = 3'd1,
        RD_WAIT = 3'd2,
        RD_BUS  = 3'd3,
        WR_LOAD = 3'd4,
        WR_MEM  = 3'd5,
        FINISH  = 3'd6
    } state_t;

endpackage

// File: rtl/mem_access_ctrl_wait_timer.sv
// Wait-cycle counter: cleared outside the wait states, counts cycles without
// mem_ready, and flags when the final permitted wait cycle is reached.
module wait_timer
    import mem_access_pkg::*;
#(
    parameter int unsigned WAIT_MAX = WAIT_MAX_DEFAULT,
    parameter int unsigned CNT_W    = CNT_W_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == CNT_W'(WAIT_MAX - 1));

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory access sequencer: drives MAR/MDR/memory strobes for single read or
// write accesses, with a bounded wait on mem_ready.
module mem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int unsigned WAIT_MAX = WAIT_MAX_DEFAULT,
    parameter int unsigned CNT_W    = CNT_W_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic req,
    input  logic req_read,
    input  logic mem_ready,
    output logic mar_load,
    output logic mdr_r_w,
    output logic mdr_in_bus_en,
    output logic mdr_in_mem_en,
    output logic mdr_out_bus_en,
    output logic mdr_out_mem_en,
    output logic mem_en,
    output logic mem_we,
    output logic busy,
    output logic done,
    output logic timeout_err
);

    if (WAIT_MAX < 1 || (64'd1 << CNT_W) <= 64'(WAIT_MAX)) begin : g_param_check
        $error("mem_access_ctrl: CNT_W too narrow for WAIT_MAX");
    end

    state_t state_q, state_d;
    logic   rd_q, rd_d;
    logic   tout_q, tout_d;
    logic   in_wait;
    logic   timer_clear;
    logic   timer_en;
    logic   expired;

    assign in_wait     = (state_q == RD_WAIT) || (state_q == WR_MEM);
    // Held clear outside the wait states so each wait begins from zero.
    assign timer_clear = !in_wait;
    assign timer_en    = in_wait && !mem_ready;

    wait_timer #(
        .WAIT_MAX (WAIT_MAX),
        .CNT_W    (CNT_W)
    ) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (timer_clear),
        .enable  (timer_en),
        .expired (expired)
    );

    always_comb begin
        state_d = state_q;
        rd_d    = rd_q;
        tout_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    rd_d    = req_read;
                    state_d = ADDR;
                end
            end
            ADDR:    state_d = rd_q ? RD_WAIT : WR_LOAD;
            RD_WAIT: begin
                if (mem_ready) begin
                    state_d = RD_BUS;
                end else if (expired) begin
                    state_d = FINISH;
                    tout_d  = 1'b1;
                end
            end
            RD_BUS:  state_d = FINISH;
            WR_LOAD: state_d = WR_MEM;
            WR_MEM: begin
                if (mem_ready) begin
                    state_d = FINISH;
                end else if (expired) begin
                    state_d = FINISH;
                    tout_d  = 1'b1;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rd_q    <= 1'b0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            tout_q  <= tout_d;
        end
    end

    always_comb begin
        mar_load       = 1'b0;
        mdr_r_w        = 1'b0;
        mdr_in_bus_en  = 1'b0;
        mdr_in_mem_en  = 1'b0;
        mdr_out_bus_en = 1'b0;
        mdr_out_mem_en = 1'b0;
        mem_en         = 1'b0;
        mem_we         = 1'b0;
        busy           = 1'b0;
        done           = 1'b0;
        timeout_err    = 1'b0;
        case (state_q)
            IDLE:    mdr_r_w = 1'b1;
            ADDR: begin
                mar_load = 1'b1;
                busy     = 1'b1;
            end
            RD_WAIT: begin
                mdr_r_w       = 1'b1;
                mem_en        = 1'b1;
                busy          = 1'b1;
                mdr_in_mem_en = mem_ready;
            end
            RD_BUS: begin
                mdr_out_bus_en = 1'b1;
                busy           = 1'b1;
            end
            WR_LOAD: begin
                mdr_in_bus_en = 1'b1;
                busy          = 1'b1;
            end
            WR_MEM: begin
                mdr_out_mem_en = 1'b1;
                mem_en         = 1'b1;
                mem_we         = 1'b1;
                busy           = 1'b1;
            end
            FINISH: begin
                done        = 1'b1;
                timeout_err = tout_q;
            end
            default: mdr_r_w = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: per-cycle checks of the full output
// vector against hand-derived state decodes, plus a per-cycle exclusivity monitor.
module tb_mem_access_ctrl;

    // Output vector order: mar_load, mdr_r_w, in_bus, in_mem, out_bus, out_mem,
    // mem_en, mem_we, busy, done, timeout_err
    localparam logic [10:0] O_IDLE   = 11'h200;
    localparam logic [10:0] O_ADDR   = 11'h404;
    localparam logic [10:0] O_RDW    = 11'h214;
    localparam logic [10:0] O_RDW_R  = 11'h294;
    localparam logic [10:0] O_RDBUS  = 11'h044;
    localparam logic [10:0] O_WRLD   = 11'h104;
    localparam logic [10:0] O_WRMEM  = 11'h03C;
    localparam logic [10:0] O_FIN    = 11'h002;
    localparam logic [10:0] O_FIN_TO = 11'h003;

    logic clk = 1'b0;
    logic reset, req, req_read, mem_ready;
    logic mar_load, mdr_r_w, mdr_in_bus_en, mdr_in_mem_en, mdr_out_bus_en;
    logic mdr_out_mem_en, mem_en, mem_we, busy, done, timeout_err;
    logic [10:0] out_vec;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(
        .WAIT_MAX (8),
        .CNT_W    (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req            (req),
        .req_read       (req_read),
        .mem_ready      (mem_ready),
        .mar_load       (mar_load),
        .mdr_r_w        (mdr_r_w),
        .mdr_in_bus_en  (mdr_in_bus_en),
        .mdr_in_mem_en  (mdr_in_mem_en),
        .mdr_out_bus_en (mdr_out_bus_en),
        .mdr_out_mem_en (mdr_out_mem_en),
        .mem_en         (mem_en),
        .mem_we         (mem_we),
        .busy           (busy),
        .done           (done),
        .timeout_err    (timeout_err)
    );

    assign out_vec = {mar_load, mdr_r_w, mdr_in_bus_en, mdr_in_mem_en, mdr_out_bus_en,
                      mdr_out_mem_en, mem_en, mem_we, busy, done, timeout_err};

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive this cycle's inputs just after the edge, then check the outputs
    // of the state entered at that edge.
    task automatic cyc(input string tag, input logic rst, input logic rq, input logic rd,
                       input logic mr, input logic [10:0] exp);
        @(posedge clk);
        #1;
        reset     = rst;
        req       = rq;
        req_read  = rd;
        mem_ready = mr;
        #1;
        check_eq(tag, {5'd0, out_vec}, {5'd0, exp});
    endtask

    always @(negedge clk) begin
        if (reset === 1'b0) begin
            check_eq("excl_in",  {15'd0, mdr_in_bus_en & mdr_in_mem_en}, 16'd0);
            check_eq("excl_out", {15'd0, mdr_out_bus_en & mdr_out_mem_en}, 16'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; req = 1'b1; req_read = 1'b1; mem_ready = 1'b1;
        @(posedge clk);
        cyc("rst_hold", 1, 1, 1, 1, O_IDLE);
        cyc("rst_idle", 0, 0, 0, 1, O_IDLE);
        cyc("idle_mr_ignored", 0, 0, 0, 0, O_IDLE);

        // Read, mem_ready in first RD_WAIT cycle; req_read flips after acceptance
        cyc("rd_req",   0, 1, 1, 0, O_IDLE);
        cyc("rd_addr",  0, 0, 0, 0, O_ADDR);
        cyc("rd_wait",  0, 0, 0, 1, O_RDW_R);
        cyc("rd_bus",   0, 0, 0, 1, O_RDBUS);
        cyc("rd_fin",   0, 1, 0, 0, O_FIN);
        cyc("rd_idle",  0, 0, 0, 0, O_IDLE);

        // Write, mem_ready after 3 wait cycles
        cyc("wr_req",   0, 1, 0, 0, O_IDLE);
        cyc("wr_addr",  0, 0, 1, 0, O_ADDR);
        cyc("wr_load",  0, 0, 1, 1, O_WRLD);
        for (int i = 0; i < 3; i++) cyc("wr_mem_wait", 0, 0, 0, 0, O_WRMEM);
        cyc("wr_mem_rdy", 0, 0, 0, 1, O_WRMEM);
        cyc("wr_fin",   0, 0, 0, 0, O_FIN);
        cyc("wr_idle",  0, 0, 0, 0, O_IDLE);

        // Read timeout: 8 RD_WAIT cycles, req toggled meanwhile
        cyc("to_req",   0, 1, 1, 0, O_IDLE);
        cyc("to_addr",  0, 0, 0, 0, O_ADDR);
        for (int i = 0; i < 8; i++) cyc("to_rd_wait", 0, 1'(i % 2), 0, 0, O_RDW);
        cyc("to_fin",   0, 0, 0, 0, O_FIN_TO);
        cyc("to_idle",  0, 0, 0, 0, O_IDLE);

        // Write timeout
        cyc("wto_req",  0, 1, 0, 0, O_IDLE);
        cyc("wto_addr", 0, 0, 0, 0, O_ADDR);
        cyc("wto_load", 0, 0, 0, 0, O_WRLD);
        for (int i = 0; i < 8; i++) cyc("wto_mem", 0, 0, 0, 0, O_WRMEM);
        cyc("wto_fin",  0, 0, 0, 0, O_FIN_TO);
        cyc("wto_idle", 0, 0, 0, 0, O_IDLE);

        // Reset during 2nd WR_MEM cycle, with req and mem_ready also high
        cyc("ra_req",   0, 1, 0, 0, O_IDLE);
        cyc("ra_addr",  0, 0, 0, 0, O_ADDR);
        cyc("ra_load",  0, 0, 0, 0, O_WRLD);
        cyc("ra_mem1",  0, 0, 0, 0, O_WRMEM);
        cyc("ra_mem2",  1, 1, 0, 1, O_WRMEM);
        cyc("ra_after", 0, 0, 0, 0, O_IDLE);
        cyc("ra_nodone", 0, 0, 0, 0, O_IDLE);
        cyc("ra_rd_req",  0, 1, 1, 0, O_IDLE);
        cyc("ra_rd_addr", 0, 0, 0, 0, O_ADDR);
        cyc("ra_rd_wait", 0, 0, 0, 1, O_RDW_R);
        cyc("ra_rd_bus",  0, 0, 0, 0, O_RDBUS);
        cyc("ra_rd_fin",  0, 0, 0, 0, O_FIN);
        cyc("ra_rd_idle", 0, 0, 0, 0, O_IDLE);

        // req held high: back-to-back reads separated by one IDLE cycle
        cyc("bb_req",   0, 1, 1, 0, O_IDLE);
        for (int k = 0; k < 2; k++) begin
            cyc("bb_addr", 0, 1, 1, 0, O_ADDR);
            cyc("bb_wait", 0, 1, 1, 1, O_RDW_R);
            cyc("bb_bus",  0, 1, 1, 0, O_RDBUS);
            cyc("bb_fin",  0, 1, 1, 0, O_FIN);
            cyc("bb_idle", 0, 1'(k == 0), 1, 0, O_IDLE);
        end
        cyc("bb_end",   0, 0, 0, 0, O_IDLE);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
